// File: rtl/systolic_ctrl_pkg.sv
// systolic_pkg: shared types and constants for the systolic array sequencer.
package systolic_pkg;

  // Default array dimension and maximum inner dimension per job
  localparam int SCTRL_ARRAY_SIZE = 4;
  localparam int SCTRL_K_MAX      = 16;

  // Cycles between the last operand read and the first valid result row:
  // one for the buffer read, one for the cell accumulator register.
  localparam int SCTRL_FLUSH_LAT  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } sctrl_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sctrl_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: host-side job handshake and result-row readout bundle.
interface systolic_ctrl_if #(
  parameter int KW = 5,
  parameter int RW = 2
);
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_row;

  // Host logic: issues jobs and consumes result rows
  modport master (
    output start, k_len, res_ready,
    input  busy, done, res_valid, res_row
  );

  // Controller side
  modport slave (
    input  start, k_len, res_ready,
    output busy, done, res_valid, res_row
  );
endinterface

// File: rtl/systolic_ctrl_lane_gen.sv
// systolic_lane_gen: read enable and k index for one skewed operand lane.
// Lane LANE is enabled while LANE <= t < LANE + k; its address is t - LANE.
module systolic_lane_gen #(
  parameter int KW   = 5,
  parameter int TW   = 5,
  parameter int LANE = 0
) (
  input  logic          active_i,
  input  logic [TW-1:0] t_i,
  input  logic [KW-1:0] k_i,
  output logic          en_o,
  output logic [KW-1:0] addr_o
);

  localparam logic [TW-1:0] LANE_T = TW'(LANE);

  logic [TW-1:0] rel;
  logic          hit;

  // Window test on the skewed cycle index; disabled lanes present address 0
  always_comb begin
    rel    = t_i - LANE_T;
    hit    = active_i && (t_i >= LANE_T) && (rel < TW'(k_i));
    en_o   = hit;
    addr_o = hit ? KW'(rel) : '0;
  end

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears the NxN output-stationary array, streams skewed A/B
// operand reads, waits out the pipeline and hands out result rows.
// Optional macro SYSTOLIC_CTRL_PERF_EN adds perf_cycles/perf_stalls counters.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter  int ARRAY_SIZE = SCTRL_ARRAY_SIZE,
  parameter  int K_MAX      = SCTRL_K_MAX,
  localparam int KW         = $clog2(K_MAX + 1),
  localparam int RW         = $clog2(ARRAY_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  systolic_ctrl_if.slave           host,
  output logic                     pe_clear,
  output logic [ARRAY_SIZE-1:0]    a_rd_en,
  output logic [ARRAY_SIZE*KW-1:0] a_rd_addr,
  output logic [ARRAY_SIZE-1:0]    b_rd_en,
  output logic [ARRAY_SIZE*KW-1:0] b_rd_addr
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_cycles,
  output logic [31:0]              perf_stalls
`endif
);

  localparam int N  = ARRAY_SIZE;
  // Issue counter spans 0 .. K_MAX + 2N - 3
  localparam int TW = $clog2(K_MAX + 2 * N);
  localparam int FW = $clog2(SCTRL_FLUSH_LAT + 1);

  localparam logic [TW-1:0] T_OFS      = TW'(2 * N - 3);
  localparam logic [KW-1:0] K_SAT      = KW'(K_MAX);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(SCTRL_FLUSH_LAT - 1);

  sctrl_state_t  state_q;
  logic [KW-1:0] k_q;
  logic [TW-1:0] t_q;
  logic          iss_q;
  logic [FW-1:0] fl_q;
  logic          busy_q;
  logic          done_q;
  logic          clr_q;
  logic          rvalid_q;
  logic [RW-1:0] row_q;

  logic [N-1:0]    a_en_q,   b_en_q;
  logic [N*KW-1:0] a_addr_q, b_addr_q;
  logic [N-1:0]    a_en_d,   b_en_d;
  logic [N*KW-1:0] a_addr_d, b_addr_d;

  logic [KW-1:0] k_cap;
  logic [TW-1:0] t_last;

  // Oversized jobs are clipped to the buffer depth; last skewed issue index
  always_comb begin
    k_cap  = (host.k_len > K_SAT) ? K_SAT : host.k_len;
    t_last = TW'(k_q) + T_OFS;
  end

  // The lane generators run one cycle ahead (issue counter starts during
  // CLEAR) so the registered enables line up exactly with the FEED window.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      systolic_lane_gen #(.KW(KW), .TW(TW), .LANE(gi)) u_a_lane (
        .active_i (iss_q),
        .t_i      (t_q),
        .k_i      (k_q),
        .en_o     (a_en_d[gi]),
        .addr_o   (a_addr_d[gi*KW +: KW])
      );
      systolic_lane_gen #(.KW(KW), .TW(TW), .LANE(gi)) u_b_lane (
        .active_i (iss_q),
        .t_i      (t_q),
        .k_i      (k_q),
        .en_o     (b_en_d[gi]),
        .addr_o   (b_addr_d[gi*KW +: KW])
      );
    end
  endgenerate

  // Register the lane enables/addresses so the buffers see glitch-free strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_en_q   <= '0;
      b_en_q   <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      a_en_q   <= a_en_d;
      b_en_q   <= b_en_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  end

  // Job sequencer with registered host and array-control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      t_q      <= '0;
      iss_q    <= 1'b0;
      fl_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_q    <= 1'b0;
      rvalid_q <= 1'b0;
      row_q    <= '0;
    end else begin
      // Skewed issue counter; stops after the last lane's last k index
      if (iss_q) begin
        if (t_q == t_last) iss_q <= 1'b0;
        else               t_q   <= t_q + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (host.start) begin
            state_q <= S_CLEAR;
            k_q     <= k_cap;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
            iss_q   <= (k_cap != '0);
            t_q     <= '0;
          end
        end
        S_CLEAR: begin
          clr_q   <= 1'b0;
          fl_q    <= '0;
          state_q <= (k_q == '0) ? S_FLUSH : S_FEED;
        end
        S_FEED: begin
          // Issue stopped last cycle, so the final reads are on the bus now
          if (!iss_q) begin
            state_q <= S_FLUSH;
            fl_q    <= '0;
          end
        end
        S_FLUSH: begin
          if (fl_q == FLUSH_LAST) begin
            state_q  <= S_DRAIN;
            rvalid_q <= 1'b1;
            row_q    <= '0;
          end else begin
            fl_q <= fl_q + FW'(1);
          end
        end
        S_DRAIN: begin
          if (host.res_ready) begin
            if (row_q == ROW_LAST) begin
              state_q  <= S_DONE;
              rvalid_q <= 1'b0;
              done_q   <= 1'b1;
              row_q    <= '0;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.res_valid = rvalid_q;
  assign host.res_row   = row_q;
  assign pe_clear       = clr_q;
  assign a_rd_en        = a_en_q;
  assign a_rd_addr      = a_addr_q;
  assign b_rd_en        = b_en_q;
  assign b_rd_addr      = b_addr_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] pcyc_q;
  logic [31:0] pstl_q;

  // Busy-cycle and drain-stall counters; cleared at job start, frozen in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (host.start) begin
        pcyc_q <= '0;
        pstl_q <= '0;
      end
    end else begin
      pcyc_q <= sctrl_sat_inc(pcyc_q);
      if (state_q == S_DRAIN && !host.res_ready) pstl_q <= sctrl_sat_inc(pstl_q);
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stalls = pstl_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench for systolic_ctrl (N=4, K_MAX=16).
// Stimulus pushes expected clear/feed/row/done events; a negedge monitor
// pops and compares them as the DUT presents them.
module tb_systolic_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int KW    = 5;
  localparam int RW    = 2;

  localparam int EV_CLEAR = 0;
  localparam int EV_FEED  = 1;
  localparam int EV_ROW   = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.KW(KW), .RW(RW)) hif ();

  logic            pe_clear;
  logic [N-1:0]    a_rd_en, b_rd_en;
  logic [N*KW-1:0] a_rd_addr, b_rd_addr;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]     perf_cycles, perf_stalls;
`endif

  systolic_ctrl #(.ARRAY_SIZE(N), .K_MAX(K_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (hif),
    .pe_clear  (pe_clear),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .b_rd_en   (b_rd_en),
    .b_rd_addr (b_rd_addr)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  edge_cnt = 0;
  int  acc_edge = 0;
  int  max_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected lane vector at skewed index t, packed like the monitor packs DUT outputs
  function automatic logic [63:0] feed_vec(input int k, input int t);
    logic [N-1:0]    en;
    logic [N*KW-1:0] ad;
    en = '0;
    ad = '0;
    for (int i = 0; i < N; i++) begin
      if (t >= i && t < i + k) begin
        en[i]          = 1'b1;
        ad[i*KW +: KW] = KW'(t - i);
      end
    end
    return {16'd0, en, en, ad, ad};
  endfunction

  task automatic push_ev(input int kind, input int cyc, input logic [63:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Queue every observable event of one job; cycles count from the start edge
  task automatic push_job(input int keff, input int stall_row, input int stall_len,
                          output int done_cyc);
    int          c;
    logic [63:0] v;
    push_ev(EV_CLEAR, 1, 64'd0);
    if (keff > 0) begin
      for (int t = 0; t <= keff + 2 * N - 3; t++) begin
        v = feed_vec(keff, t);
        if (v != 64'd0) push_ev(EV_FEED, 2 + t, v);
      end
    end
    c = (keff == 0) ? 4 : keff + 2 * N + 2;
    for (int r = 0; r < N; r++) begin
      if (r == stall_row) c += stall_len;
      push_ev(EV_ROW, c, 64'(r));
      c++;
    end
    push_ev(EV_DONE, c, 64'd0);
    done_cyc = c;
  endtask

  task automatic sb_pop(input int kind, input int cyc, input logic [63:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got kind=%0d cyc=%0d val=%0h, expected no event", kind, cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
        failures++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d val=%0h expected kind=%0d cyc=%0d val=%0h",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end else begin
        $display("txn kind=%0d cyc=%0d val=%0h ok", kind, cyc, val);
      end
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: the DUT presenting clear, lane reads, a row handshake or done
  always @(negedge clk) begin
    int rel;
    if (reset) begin
      rel = edge_cnt - acc_edge + 1;
      if (hif.start && !hif.busy) acc_edge = edge_cnt + 1;
      if (pe_clear) sb_pop(EV_CLEAR, rel, 64'd0);
      if (a_rd_en != '0 || b_rd_en != '0)
        sb_pop(EV_FEED, rel, {16'd0, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr});
      if (hif.res_valid && hif.res_ready) sb_pop(EV_ROW, rel, 64'(hif.res_row));
      if (hif.done) sb_pop(EV_DONE, rel, 64'd0);
      for (int i = 0; i < N; i++) begin
        if (a_rd_en[i] && int'(a_rd_addr[i*KW +: KW]) > max_addr) max_addr = int'(a_rd_addr[i*KW +: KW]);
        if (b_rd_en[i] && int'(b_rd_addr[i*KW +: KW]) > max_addr) max_addr = int'(b_rd_addr[i*KW +: KW]);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      64'(hif.busy), 64'd0);
    chk({tag, "_done"},      64'(hif.done), 64'd0);
    chk({tag, "_pe_clear"},  64'(pe_clear), 64'd0);
    chk({tag, "_a_rd_en"},   64'(a_rd_en), 64'd0);
    chk({tag, "_b_rd_en"},   64'(b_rd_en), 64'd0);
    chk({tag, "_a_rd_addr"}, 64'(a_rd_addr), 64'd0);
    chk({tag, "_b_rd_addr"}, 64'(b_rd_addr), 64'd0);
    chk({tag, "_res_valid"}, 64'(hif.res_valid), 64'd0);
    chk({tag, "_res_row"},   64'(hif.res_row), 64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk({tag, "_perf_cycles"}, perf_cycles, 64'd0);
    chk({tag, "_perf_stalls"}, perf_stalls, 64'd0);
`endif
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (hif.done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  // One job: optional 5-cycle ready stall at stall_row, optional start pulse
  task automatic run_job(input int k_in, input int stall_row, input int pulse_cyc, input string tag);
    int keff, done_c, cyc, stall_cnt, slen;
    bit armed, got, pulse_now;
    keff = (k_in > K_MAX) ? K_MAX : k_in;
    slen = (stall_row > 0) ? 5 : 0;
    push_job(keff, stall_row, slen, done_c);
    max_addr = 0;
    @(posedge clk); #1;
    hif.start     = 1'b1;
    hif.k_len     = KW'(k_in);
    hif.res_ready = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    cyc       = 1;
    got       = 1'b0;
    stall_cnt = 0;
    armed     = (stall_row > 0);
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      pulse_now = (cyc == pulse_cyc);
      if (hif.done) begin
        got = 1'b1;
      end else begin
        if (stall_cnt > 0) begin
          chk({tag, "_stall_row"},   64'(hif.res_row), 64'(stall_row));
          chk({tag, "_stall_valid"}, 64'(hif.res_valid), 64'd1);
          stall_cnt--;
        end else if (armed && hif.res_valid && hif.res_row == RW'(stall_row - 1)) begin
          stall_cnt = 5;
          armed     = 1'b0;
        end
        @(posedge clk); #1;
        hif.start     = pulse_now;
        hif.res_ready = (stall_cnt == 0);
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    hif.start = 1'b0;
    chk({tag, "_idle_busy"}, 64'(hif.busy), 64'd0);
    chk({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk({tag, "_perf_cycles"}, perf_cycles, 64'(done_c));
    chk({tag, "_perf_stalls"}, perf_stalls, 64'(slen));
`endif
  endtask

  initial begin
    int d1, d2;
    hif.start     = 1'b0;
    hif.k_len     = '0;
    hif.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // k=3 with a start pulse in FEED that must be ignored
    run_job(3, -1, 5, "k3");
    run_job(0, -1, -1, "k0");
    run_job(20, -1, -1, "k20");
    chk("k20_max_addr", 64'(max_addr), 64'd15);
    run_job(1, 2, -1, "stall");

    // Reset asserted in the middle of FEED
    push_job(4, -1, 0, d1);
    @(posedge clk); #1;
    hif.start = 1'b1;
    hif.k_len = KW'(4);
    @(posedge clk); #1;
    hif.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_zero("abort");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    run_job(2, -1, -1, "after_rst");

    // Back-to-back jobs with start held high
    push_job(2, -1, 0, d1);
    push_job(1, -1, 0, d2);
    @(posedge clk); #1;
    hif.start = 1'b1;
    hif.k_len = KW'(2);
    @(posedge clk); #1;
    hif.k_len = KW'(1);
    wait_done("b2b_first");
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_gap_busy", 64'(hif.busy), 64'd0);
    @(posedge clk); #1;
    hif.start = 1'b0;
    @(negedge clk);
    chk("b2b_pe_clear", 64'(pe_clear), 64'd1);
    chk("b2b_busy", 64'(hif.busy), 64'd1);
    wait_done("b2b_second");
    @(posedge clk); #1;
    chk("b2b_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
